// File: rtl/conv_pkg.sv
// conv_pkg: shared types, requant widths and output-size helper for the conv layer
package conv_pkg;
  typedef enum logic [1:0] {ACT_NONE, ACT_RELU, ACT_RELU6} act_mode_e;
  typedef enum logic [2:0] {IDLE, CLR, MAC, REQ, WR, FIN} conv_state_e;
  localparam int RQ_W = 48;
  localparam int SCALE_W = 16;
  localparam int BIAS_W = 32;
  function automatic int out_dim(input int n, input int k, input int s, input int pad);
    return (n + 2 * (pad != 0 ? (k - 1) / 2 : 0) - k) / s + 1;
  endfunction
endpackage

// File: rtl/conv_requant.sv
// conv_requant: registered scale + bias + round + shift, then activation clamp and saturation
module conv_requant import conv_pkg::*; #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 4,
  parameter int SHIFT = 8,
  parameter int ACT_MODE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [SCALE_W-1:0] scale,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [OUT_W-1:0] q
);
  localparam act_mode_e MODE = act_mode_e'(ACT_MODE);
  localparam logic signed [RQ_W-1:0] OMAX = RQ_W'((64'sd1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [RQ_W-1:0] OMIN = -OMAX - RQ_W'(1);
  // activation and output saturation collapse into one [LO, HI] window
  localparam logic signed [RQ_W-1:0] HI = (MODE == ACT_RELU6 && OMAX > RQ_W'(6)) ? RQ_W'(6) : OMAX;
  localparam logic signed [RQ_W-1:0] LO = MODE == ACT_NONE ? OMIN : RQ_W'(0);
  logic signed [RQ_W-1:0] t, s;
  always_comb begin
    t = RQ_W'(acc) * RQ_W'(scale) + RQ_W'(bias) + (RQ_W'(1) <<< (SHIFT - 1));
    s = t >>> SHIFT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= OUT_W'(s < LO ? LO : s > HI ? HI : s);
  end
endmodule

// File: rtl/conv2d_bn_act_param.sv
// conv2d_bn_act_param: one-MAC-per-cycle conv2d with folded batch-norm requant and activation
module conv2d_bn_act_param import conv_pkg::*; #(
  parameter int H = 16,
  parameter int W = 16,
  parameter int CIN = 32,
  parameter int COUT = 64,
  parameter int K = 3,
  parameter int STRIDE = 1,
  parameter int PAD = 1,
  parameter int IN_W = 4,
  parameter int OUT_W = 4,
  parameter int ACC_W = 24,
  parameter int SHIFT = 8,
  parameter int ACT_MODE = 2,
  parameter string WEIGHT_FILE = "",
  parameter string SCALE_FILE = "",
  parameter string BIAS_FILE = ""
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic in_we,
  input  logic [31:0] in_addr,
  input  logic signed [IN_W-1:0] in_data,
  input  logic [31:0] read_addr,
  output logic signed [OUT_W-1:0] read_data,
  output logic busy,
  output logic done
);
  localparam int P = PAD != 0 ? (K - 1) / 2 : 0;
  localparam int H_OUT = out_dim(H, K, STRIDE, PAD);
  localparam int W_OUT = out_dim(W, K, STRIDE, PAD);
  localparam int N = K * K * CIN;
  localparam int PW = 2 * IN_W;
  localparam int IN_DEPTH = CIN * H * W;
  localparam int OUT_DEPTH = COUT * H_OUT * W_OUT;
  localparam int W_DEPTH = COUT * CIN * K * K;
  localparam int IAW = IN_DEPTH > 1 ? $clog2(IN_DEPTH) : 1;
  localparam int OAW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int WAW = W_DEPTH > 1 ? $clog2(W_DEPTH) : 1;
  localparam int CAW = COUT > 1 ? $clog2(COUT) : 1;
  conv_state_e st;
  logic signed [IN_W-1:0] in_ram [IN_DEPTH];
  logic signed [OUT_W-1:0] out_ram [OUT_DEPTH];
  // weights laid out as ((co*CIN+ci)*K+ky)*K+kx
  logic signed [IN_W-1:0] weight_rom [W_DEPTH];
  logic signed [SCALE_W-1:0] scale_rom [COUT];
  logic signed [BIAS_W-1:0] bias_rom [COUT];
  logic [31:0] co, oy, ox, ci, ky, kx, cnt;
  logic signed [31:0] iy, ix;
  logic [IAW-1:0] ia;
  logic [WAW-1:0] wa;
  logic [OAW-1:0] oa;
  logic iss, tap_ok, ok_q, last;
  logic signed [IN_W-1:0] in_q, w_q;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] q;
  // cnt counts issued taps; the MAC phase ends once all N have been issued and consumed
  always_comb begin
    iy = $signed(oy * STRIDE + ky) - P;
    ix = $signed(ox * STRIDE + kx) - P;
    tap_ok = iy >= 0 && iy < H && ix >= 0 && ix < W;
    iss = st == CLR || (st == MAC && cnt != N);
    ia = IAW'((ci * H + iy) * W + ix);
    wa = WAW'(((co * CIN + ci) * K + ky) * K + kx);
    oa = OAW'((co * H_OUT + oy) * W_OUT + ox);
    prod = ok_q ? in_q * w_q : PW'(0);
    last = co == COUT - 1 && oy == H_OUT - 1 && ox == W_OUT - 1;
  end
  always_ff @(posedge clk) begin
    if (in_we && !busy && in_addr < IN_DEPTH) in_ram[in_addr[IAW-1:0]] <= in_data;
    if (iss && tap_ok) begin
      in_q <= in_ram[ia];
      w_q <= weight_rom[wa];
    end
    if (st == WR) out_ram[oa] <= q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      read_data <= '0;
      acc <= '0;
      ok_q <= 1'b0;
      {co, oy, ox, ci, ky, kx, cnt} <= '0;
    end else begin
      read_data <= read_addr < OUT_DEPTH ? out_ram[OAW'(read_addr)] : '0;
      ok_q <= iss && tap_ok;
      if (iss) begin
        cnt <= cnt + 1;
        kx <= kx == K - 1 ? '0 : kx + 1;
        if (kx == K - 1) ky <= ky == K - 1 ? '0 : ky + 1;
        if (kx == K - 1 && ky == K - 1) ci <= ci + 1;
      end
      case (st)
        IDLE: if (start) begin
          st <= CLR;
          busy <= 1'b1;
          done <= 1'b0;
        end
        CLR: begin
          acc <= '0;
          st <= MAC;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (cnt == N) st <= REQ;
        end
        REQ: st <= WR;
        WR: begin
          {ci, ky, kx, cnt} <= '0;
          ox <= ox == W_OUT - 1 ? '0 : ox + 1;
          if (ox == W_OUT - 1) oy <= oy == H_OUT - 1 ? '0 : oy + 1;
          if (ox == W_OUT - 1 && oy == H_OUT - 1) co <= co == COUT - 1 ? '0 : co + 1;
          st <= last ? FIN : CLR;
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        FIN: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
  conv_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ACT_MODE(ACT_MODE)) requant (
    .clk(clk),
    .reset(reset),
    .en(st == REQ),
    .acc(acc),
    .scale(scale_rom[CAW'(co)]),
    .bias(bias_rom[CAW'(co)]),
    .q(q)
  );
endmodule
